// File: rtl/lmsm_pkg.sv
// Shared definitions for the load/store-multiple engine.
package lmsm_pkg;

  localparam int unsigned LMSM_DATA_W = 16;
  localparam int unsigned LMSM_ADDR_W = 16;
  localparam int unsigned LMSM_NREG   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } lmsm_state_e;

  // Register-index width; a single-register file still needs one index bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: index of the least significant 1 in vec.
module prio_enc_lsb
  import lmsm_pkg::*;
#(
  parameter int unsigned NREG = LMSM_NREG,
  localparam int unsigned RIDX_W = idx_width(NREG)
) (
  input  logic [NREG-1:0]   vec,
  output logic [RIDX_W-1:0] index,
  output logic              valid
);

  // Scan upward; the first hit wins, so the result is the lowest set bit.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (vec[i] && !valid) begin
        index = RIDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_engine.sv
// Load/store-multiple engine: moves the registers selected by a mask to or
// from consecutive memory words, lowest register index first.
module lmsm_engine
  import lmsm_pkg::*;
#(
  parameter int unsigned DATA_W = LMSM_DATA_W,
  parameter int unsigned ADDR_W = LMSM_ADDR_W,
  parameter int unsigned NREG   = LMSM_NREG,
  localparam int unsigned RIDX_W = idx_width(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREG-1:0]   mask,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] end_addr,
  output logic [RIDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_wen,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  lmsm_state_e       state, state_nxt;
  logic [NREG-1:0]   rem_mask, rem_mask_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              store_q, store_nxt;
  logic [RIDX_W-1:0] cur_idx;
  logic              cur_valid;

  prio_enc_lsb #(.NREG(NREG)) u_prio (
    .vec   (rem_mask),
    .index (cur_idx),
    .valid (cur_valid)
  );

  // The running address doubles as end_addr: it only moves during a transfer
  // and is reloaded on the next accepted start.
  assign end_addr  = addr;
  assign mem_addr  = addr;
  assign mem_wdata = rf_rdata;
  assign rf_raddr  = cur_idx;
  assign rf_waddr  = cur_idx;
  assign rf_wdata  = mem_rdata;

  // State and transfer context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rem_mask <= '0;
      addr     <= '0;
      store_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem_mask <= rem_mask_nxt;
      addr     <= addr_nxt;
      store_q  <= store_nxt;
    end
  end

  // Next-state logic and per-state outputs.
  always_comb begin
    state_nxt    = state;
    rem_mask_nxt = rem_mask;
    addr_nxt     = addr;
    store_nxt    = store_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    rf_wen       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          rem_mask_nxt = mask;
          addr_nxt     = base_addr;
          store_nxt    = is_store;
          state_nxt    = (mask == '0) ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        busy = 1'b1;
        // An empty mask cannot reach XFER; finishing is the safe fallback.
        if (!cur_valid) begin
          state_nxt = ST_DONE;
        end else begin
          mem_req = 1'b1;
          mem_we  = store_q;
          if (mem_ack) begin
            rf_wen       = !store_q;
            rem_mask_nxt = rem_mask & ~(NREG'(1) << cur_idx);
            addr_nxt     = addr + ADDR_W'(1);
            if (rem_mask_nxt == '0) state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lmsm_engine.sv
// Scoreboard bench for lmsm_engine: stimulus pushes expected transfers and
// completions; an independent monitor pops and compares them.
module tb_lmsm_engine;
  import lmsm_pkg::*;

  localparam int DW = LMSM_DATA_W;
  localparam int AW = LMSM_ADDR_W;
  localparam int NR = LMSM_NREG;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset, start, is_store;
  logic [NR-1:0] mask;
  logic [AW-1:0] base_addr;
  logic          busy, done;
  logic [AW-1:0] end_addr;
  logic [RW-1:0] rf_raddr, rf_waddr;
  logic [DW-1:0] rf_rdata, rf_wdata;
  logic          rf_wen;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack = 1'b0;

  always #5 clk = ~clk;

  lmsm_engine #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .mask(mask), .base_addr(base_addr), .busy(busy), .done(done),
    .end_addr(end_addr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Register file source (read-only from the bench side) and memory contents.
  logic [DW-1:0] rf_mem [NR];
  assign rf_rdata = rf_mem[rf_raddr];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = DW'(a) * DW'(16'h9E37);
    return t ^ DW'(16'h5A5A);
  endfunction
  assign mem_rdata = mem_val(mem_addr);

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [RW-1:0] idx;
    logic [DW-1:0] data;
  } xfer_t;
  typedef struct {
    logic [AW-1:0] end_addr;
    int            start_cyc;
    int            lat;
  } done_t;

  xfer_t exp_q[$];
  done_t done_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0;
  int ack_mode = 0;
  bit force_noack = 1'b0;
  int wait_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: mode 0 acks every cycle, mode 1 waits two cycles per
  // request, mode 2 acks at random (also while no request is pending).
  initial forever begin
    @(negedge clk);
    #1;
    if (force_noack) mem_ack = 1'b0;
    else if (mem_req) begin
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: if (wait_cnt >= 2) begin mem_ack = 1'b1; wait_cnt = 0; end
           else begin mem_ack = 1'b0; wait_cnt++; end
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
    end else begin
      wait_cnt = 0;
      mem_ack = (ack_mode == 1) ? 1'b0 : (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare every request cycle and every done pulse with the queues.
  initial begin
    xfer_t e;
    done_t d;
    forever begin
      @(negedge clk);
      #3;
      if (reset) continue;
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_req: got mem_req=1 addr=%0h expected no request", mem_addr);
        end else begin
          e = exp_q[0];
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          check("mem_we", 64'(mem_we), 64'(e.we));
          if (e.we) begin
            check("rf_raddr", 64'(rf_raddr), 64'(e.idx));
            check("mem_wdata", 64'(mem_wdata), 64'(e.data));
          end
          if (mem_ack) begin
            if (!e.we) begin
              check("rf_wen_load", 64'(rf_wen), 64'(1));
              check("rf_waddr", 64'(rf_waddr), 64'(e.idx));
              check("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end else check("rf_wen_store", 64'(rf_wen), 64'(0));
            void'(exp_q.pop_front());
          end else check("rf_wen_wait", 64'(rf_wen), 64'(0));
        end
      end else begin
        check("rf_wen_idle", 64'(rf_wen), 64'(0));
        check("mem_we_idle", 64'(mem_we), 64'(0));
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_done: got done=1 expected 0");
        end else begin
          d = done_q.pop_front();
          check("end_addr", 64'(end_addr), 64'(d.end_addr));
          check("busy_in_done", 64'(busy), 64'(1));
          check("xfers_left", 64'(exp_q.size()), 64'(0));
          if (d.lat >= 0) check("done_latency", 64'(cyc - d.start_cyc), 64'(d.lat));
        end
        done_cnt++;
      end
    end
  end

  // Reference model: one transfer per set mask bit, ascending, consecutive addresses.
  task automatic push_expect(input bit st, input logic [NR-1:0] m, input logic [AW-1:0] b,
                             input int mode);
    xfer_t e;
    done_t d;
    int k = 0;
    for (int i = 0; i < NR; i++) begin
      if (m[i]) begin
        e.addr = b + AW'(k);
        e.we   = st;
        e.idx  = RW'(i);
        e.data = st ? rf_mem[i] : mem_val(e.addr);
        exp_q.push_back(e);
        k++;
      end
    end
    d.end_addr  = b + AW'(k);
    d.start_cyc = cyc;
    d.lat       = (mode == 0) ? k + 1 : -1;
    done_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_xfer(input bit st, input logic [NR-1:0] m, input logic [AW-1:0] b,
                          input int mode, input bit repulse);
    int prev;
    @(negedge clk);
    ack_mode  = mode;
    start     = 1'b1;
    is_store  = st;
    mask      = m;
    base_addr = b;
    push_expect(st, m, b, mode);
    prev = done_cnt;
    @(negedge clk);
    start     = 1'b0;
    mask      = NR'($urandom);
    base_addr = AW'($urandom);
    is_store  = 1'($urandom);
    if (repulse) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 400 && done_cnt == prev; t++) @(negedge clk);
    if (done_cnt == prev) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done within 400 cycles expected one pulse");
      exp_q.delete();
      done_q.delete();
      do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; mask = '0; base_addr = '0;
    for (int i = 0; i < NR; i++) rf_mem[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    #4;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_rf_wen", 64'(rf_wen), 64'(0));
    check("rst_end_addr", 64'(end_addr), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    run_xfer(1'b0, 8'b1000_0101, 16'h0040, 0, 1'b0);
    run_xfer(1'b1, 8'hFF, 16'h0100, 1, 1'b0);
    run_xfer(1'b0, 8'h00, 16'h1234, 0, 1'b0);
    run_xfer(1'b1, 8'b0000_0011, 16'hFFFF, 0, 1'b0);
    run_xfer(1'b0, 8'b0000_0011, 16'hFFFF, 2, 1'b0);

    // Reset in the cycle after the first of three load acks.
    @(negedge clk);
    ack_mode = 0; start = 1'b1; is_store = 1'b0; mask = 8'b0001_0110; base_addr = 16'h0200;
    push_expect(1'b0, 8'b0001_0110, 16'h0200, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1; force_noack = 1'b1;
    #4;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    reset = 1'b0; force_noack = 1'b0;
    #4;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_mem_req", 64'(mem_req), 64'(0));
    check("midrst_rf_wen", 64'(rf_wen), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_end_addr", 64'(end_addr), 64'(0));
    run_xfer(1'b0, 8'b0001_0110, 16'h0200, 0, 1'b0);

    run_xfer(1'b1, 8'h5A, 16'h0300, 1, 1'b1);
    run_xfer(1'b0, 8'hC3, 16'h0400, 1, 1'b1);

    for (int n = 0; n < 30; n++)
      run_xfer(1'($urandom), ($urandom_range(0, 4) == 0) ? NR'(0) : NR'($urandom),
               AW'($urandom), int'($urandom_range(0, 2)), 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
